// File: rtl/axi_lite_timer.sv
// AXI4-Lite timer/compare peripheral: COUNT/COMPARE with MATCH/OVF flags and IRQ.
// Define AXI_TIMER_PRESCALER_EN to add an 8-bit prescaler in CTRL[15:8].
module axi_lite_timer #(
   parameter int          AXI_DWIDTH    = 32,
   parameter int          AXI_AWIDTH    = 32,
   parameter logic [31:0] RESET_COMPARE = 32'hFFFFFFFF
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [AXI_AWIDTH-1:0] S_AWADDR,
   input  logic [2:0]            S_AWPROT,
   input  logic                  S_AWVALID,
   output logic                  S_AWREADY,
   input  logic [AXI_DWIDTH-1:0] S_WDATA,
   input  logic [3:0]            S_WSTRB,
   input  logic                  S_WVALID,
   output logic                  S_WREADY,
   output logic [1:0]            S_BRESP,
   output logic                  S_BVALID,
   input  logic                  S_BREADY,
   input  logic [AXI_AWIDTH-1:0] S_ARADDR,
   input  logic [2:0]            S_ARPROT,
   input  logic                  S_ARVALID,
   output logic                  S_ARREADY,
   output logic [AXI_DWIDTH-1:0] S_RDATA,
   output logic [1:0]            S_RRESP,
   output logic                  S_RVALID,
   input  logic                  S_RREADY,
   output logic                  IRQ
);

   logic        aw_full, w_full, bvalid, rvalid, irq;
   logic [1:0]  aw_idx;
   logic [31:0] w_data, rdata;
   logic [3:0]  w_strb;
   logic        en, arl, ie, match, ovf;
   logic [31:0] count, compare;
   logic [31:0] ctrl_rd, rd_val, count_n;
   logic        aw_hs, w_hs, ar_hs, wr, tick, hit;
   logic        wr_ctrl, wr_count, wr_cmp, wr_stat;
   logic        set_m, set_o;
   logic [1:0]  wa, clr;
   logic [31:0] wd, mask;
   logic [3:0]  ws;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [31:0] m);
      return (old & ~m) | (nw & m);
   endfunction

   assign S_AWREADY = !aw_full && !bvalid;
   assign S_WREADY  = !w_full && !bvalid;
   assign S_ARREADY = !rvalid;
   assign S_BVALID  = bvalid;
   assign S_RVALID  = rvalid;
   assign S_RDATA   = rdata;
   assign S_BRESP   = 2'b00;
   assign S_RRESP   = 2'b00;
   assign IRQ       = irq;

   assign aw_hs = S_AWVALID && S_AWREADY;
   assign w_hs  = S_WVALID && S_WREADY;
   assign ar_hs = S_ARVALID && S_ARREADY;
   assign wr    = (aw_full || aw_hs) && (w_full || w_hs);

   // A latched beat takes precedence over the bus side of the same channel
   assign wa   = aw_full ? aw_idx : S_AWADDR[3:2];
   assign wd   = w_full ? w_data : S_WDATA;
   assign ws   = w_full ? w_strb : S_WSTRB;
   assign mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};

   assign wr_ctrl  = wr && (wa == 2'd0);
   assign wr_count = wr && (wa == 2'd1);
   assign wr_cmp   = wr && (wa == 2'd2);
   assign wr_stat  = wr && (wa == 2'd3);
   assign clr      = wr_stat ? (wd[1:0] & {2{ws[0]}}) : 2'b00;

`ifdef AXI_TIMER_PRESCALER_EN
   logic [7:0] presc, psc;
   assign tick    = en && (psc == presc);
   assign ctrl_rd = {16'd0, presc, 5'd0, ie, arl, en};
`else
   assign tick    = en;
   assign ctrl_rd = {29'd0, ie, arl, en};
`endif

   always_comb begin
      rd_val = 32'd0;
      case (S_ARADDR[3:2])
         2'd0:    rd_val = ctrl_rd;
         2'd1:    rd_val = count;
         2'd2:    rd_val = compare;
         default: rd_val = {30'd0, ovf, match};
      endcase
   end

   assign hit = (count == compare);

   always_comb begin
      count_n = count;
      set_m   = 1'b0;
      set_o   = 1'b0;
      if (tick) begin
         set_m = hit;
         if (hit && arl) begin
            count_n = 32'd0;
         end else begin
            count_n = count + 32'd1;
            set_o   = !hit && (count == 32'hFFFFFFFF);
         end
      end
      if (wr_count) count_n = merge(count, wd, mask);
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         aw_full <= 1'b0;
         aw_idx  <= 2'd0;
         w_full  <= 1'b0;
         w_data  <= 32'd0;
         w_strb  <= 4'd0;
         bvalid  <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= 32'd0;
         en      <= 1'b0;
         arl     <= 1'b0;
         ie      <= 1'b0;
         count   <= 32'd0;
         compare <= RESET_COMPARE;
         match   <= 1'b0;
         ovf     <= 1'b0;
         irq     <= 1'b0;
`ifdef AXI_TIMER_PRESCALER_EN
         presc   <= 8'd0;
         psc     <= 8'd0;
`endif
      end else begin
         if (wr) begin
            aw_full <= 1'b0;
         end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AWADDR[3:2];
         end
         if (wr) begin
            w_full <= 1'b0;
         end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= S_WDATA;
            w_strb <= S_WSTRB;
         end
         if (wr)            bvalid <= 1'b1;
         else if (S_BREADY) bvalid <= 1'b0;
         if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_val;
         end else if (S_RREADY) begin
            rvalid <= 1'b0;
         end
         if (wr_ctrl && ws[0]) begin
            en  <= wd[0];
            arl <= wd[1];
            ie  <= wd[2];
         end
`ifdef AXI_TIMER_PRESCALER_EN
         if (wr_ctrl && ws[1]) presc <= wd[15:8];
         if (wr_ctrl)          psc <= 8'd0;
         else if (en)          psc <= tick ? 8'd0 : psc + 8'd1;
`endif
         if (wr_cmp) compare <= merge(compare, wd, mask);
         count <= count_n;
         match <= (match && !clr[0]) || set_m;
         ovf   <= (ovf && !clr[1]) || set_o;
         irq   <= match && ie;
      end
   end

   logic unused;
   assign unused = ^{S_AWPROT, S_ARPROT,
                     S_AWADDR[AXI_AWIDTH-1:4], S_AWADDR[1:0],
                     S_ARADDR[AXI_AWIDTH-1:4], S_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_timer.sv
// Directed self-checking bench for axi_lite_timer.
// Each task drives one scenario and checks port-visible results inline.
module tb_axi_lite_timer;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic        irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_lite_timer dut (
      .ACLK(clk), .ARESETN(aresetn),
      .S_AWADDR(awaddr), .S_AWPROT(awprot), .S_AWVALID(awvalid),
      .S_AWREADY(awready),
      .S_WDATA(wdata), .S_WSTRB(wstrb), .S_WVALID(wvalid),
      .S_WREADY(wready),
      .S_BRESP(bresp), .S_BVALID(bvalid), .S_BREADY(bready),
      .S_ARADDR(araddr), .S_ARPROT(arprot), .S_ARVALID(arvalid),
      .S_ARREADY(arready),
      .S_RDATA(rdata), .S_RRESP(rresp), .S_RVALID(rvalid),
      .S_RREADY(rready),
      .IRQ(irq)
   );

   // All tasks start and end 1 time unit after a rising edge
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      int  n;
      bit  awd, wdn;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      awd = 1'b0; wdn = 1'b0; n = 0;
      while (!(awd && wdn) && n < 20) begin
         if (awvalid && awready) awd = 1'b1;
         if (wvalid && wready) wdn = 1'b1;
         @(posedge clk); #1; n++;
         if (awd) awvalid = 1'b0;
         if (wdn) wvalid = 1'b0;
      end
      n = 0;
      while (!bvalid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (!bvalid) begin
         errors++;
         $display("FAIL write_timeout addr %h bvalid %b required 1", a, bvalid);
      end
      @(posedge clk); #1;
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                           output int lat);
      int n;
      araddr = a; arvalid = 1'b1; rready = 1'b0; n = 0;
      while (!arready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      arvalid = 1'b0; lat = 1;
      while (!rvalid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      checks++;
      if (!rvalid) begin
         errors++;
         $display("FAIL read_timeout addr %h rvalid %b required 1", a, rvalid);
      end
      d = rdata;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int lat;
      logic [31:0] exp_v [4];
      exp_v[0] = 32'h0; exp_v[1] = 32'h0;
      exp_v[2] = 32'hFFFFFFFF; exp_v[3] = 32'h0;
      aresetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b111000) begin
         errors++;
         $display("FAIL reset_handshake got %b required 111000",
                  {awready, wready, arready, bvalid, rvalid, irq});
      end
      checks++;
      if (rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h required 0", rdata);
      end
      aresetn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         axi_read(i * 4, d, lat);
         checks++;
         if (d !== exp_v[i]) begin
            errors++;
            $display("FAIL reset_reg%0d got %h required %h", i, d, exp_v[i]);
         end
         checks++;
         if (lat !== 1) begin
            errors++;
            $display("FAIL read_latency got %0d required 1", lat);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int lat;
      awaddr = 32'h4; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      araddr = 32'h0; arvalid = 1'b1;
      @(posedge clk); #1;
      arvalid = 1'b0;
      aresetn = 1'b0;
      @(posedge clk); #1;
      aresetn = 1'b1;
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
         errors++;
         $display("FAIL midreset_state got %b required 11100",
                  {awready, wready, arready, bvalid, rvalid});
      end
      wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge clk); #1;
      wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_stale_aw bvalid %b required 0", bvalid);
      end
      awaddr = 32'h8; awvalid = 1'b1; bready = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         errors++;
         $display("FAIL midreset_b bvalid %b bresp %b required 1 00", bvalid, bresp);
      end
      @(posedge clk); #1;
      bready = 1'b0;
      axi_read(32'h8, d, lat);
      checks++;
      if (d !== 32'h99) begin
         errors++;
         $display("FAIL midreset_cmp got %h required 00000099", d);
      end
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL midreset_count got %h required 0", d);
      end
   endtask

   task automatic test_slow_write();
      logic [31:0] d;
      int lat;
      awaddr = 32'h8; awvalid = 1'b1; bready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) begin
            wdata = 32'h10; wstrb = 4'hF; wvalid = 1'b1;
         end
         checks++;
         if (awready !== (c == 0)) begin
            errors++;
            $display("FAIL slow_awready cyc %0d got %b required %b", c, awready, c == 0);
         end
         checks++;
         if (bvalid !== (c >= 4)) begin
            errors++;
            $display("FAIL slow_bvalid cyc %0d got %b required %b", c, bvalid, c >= 4);
         end
         if (c == 7) bready = 1'b1;
         @(posedge clk); #1;
         if (c == 0) awvalid = 1'b0;
         if (c == 3) wvalid = 1'b0;
      end
      bready = 1'b0;
      checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         errors++;
         $display("FAIL slow_bdone bvalid %b awready %b required 0 1", bvalid, awready);
      end
      axi_read(32'h8, d, lat);
      checks++;
      if (d !== 32'h10) begin
         errors++;
         $display("FAIL slow_cmp got %h required 00000010", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int lat;
      awaddr = 32'h8; wstrb = 4'hF; bready = 1'b1;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int c = 0; c < 4; c++) begin
         wdata = (c < 2) ? 32'h20 : 32'h30;
         checks++;
         if (awready !== (c % 2 == 0) || bvalid !== (c % 2 == 1)) begin
            errors++;
            $display("FAIL b2b cyc %0d awready %b bvalid %b required %b %b",
                     c, awready, bvalid, c % 2 == 0, c % 2 == 1);
         end
         @(posedge clk); #1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      @(posedge clk); #1;
      bready = 1'b0;
      axi_read(32'h8, d, lat);
      checks++;
      if (d !== 32'h30) begin
         errors++;
         $display("FAIL b2b_cmp got %h required 00000030", d);
      end
   endtask

   task automatic test_autoreload_irq();
      logic [31:0] d;
      int lat;
      axi_write(32'h8, 32'h5, 4'hF);
      axi_write(32'h4, 32'h0, 4'hF);
      axi_write(32'h0, 32'h7, 4'hF);
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL ar_count1 got %h required 1", d);
      end
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'h3) begin
         errors++;
         $display("FAIL ar_count3 got %h required 3", d);
      end
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (irq !== (c == 2)) begin
            errors++;
            $display("FAIL ar_irq step %0d got %b required %b", c, irq, c == 2);
         end
         if (c < 2) begin
            @(posedge clk); #1;
         end
      end
      axi_read(32'hC, d, lat);
      checks++;
      if (d !== 32'h1) begin
         errors++;
         $display("FAIL ar_status got %h required 1", d);
      end
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'h3) begin
         errors++;
         $display("FAIL ar_reload got %h required 3", d);
      end
      axi_write(32'hC, 32'h1, 4'hF);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL w1c_vs_match irq %b required 1", irq);
      end
      awaddr = 32'hC; wdata = 32'h1; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      checks++;
      if (bvalid !== 1'b1 || irq !== 1'b1) begin
         errors++;
         $display("FAIL w1c_step1 bvalid %b irq %b required 1 1", bvalid, irq);
      end
      @(posedge clk); #1;
      bready = 1'b0;
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL w1c_irq_fall got %b required 0", irq);
      end
      axi_write(32'h0, 32'h0, 4'hF);
      axi_read(32'hC, d, lat);
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL w1c_status got %h required 0", d);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      int lat;
      axi_write(32'h8, 32'h10, 4'hF);
      axi_write(32'h4, 32'hFFFFFFFE, 4'hF);
      axi_write(32'hC, 32'h3, 4'hF);
      axi_write(32'h0, 32'h1, 4'hF);
      @(posedge clk); #1;
      axi_read(32'hC, d, lat);
      checks++;
      if (d !== 32'h2) begin
         errors++;
         $display("FAIL ovf_status got %h required 2", d);
      end
      axi_write(32'h0, 32'h0, 4'hF);
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'h3) begin
         errors++;
         $display("FAIL ovf_count got %h required 3", d);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL ovf_irq got %b required 0", irq);
      end
   endtask

   task automatic test_count_write();
      logic [31:0] d;
      int lat;
      axi_write(32'hC, 32'h3, 4'hF);
      axi_write(32'h0, 32'h1, 4'hF);
      axi_write(32'h4, 32'h100, 4'hF);
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'h101) begin
         errors++;
         $display("FAIL cw_count got %h required 00000101", d);
      end
      axi_write(32'h4, 32'hAB000000, 4'b1000);
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'hAB000104) begin
         errors++;
         $display("FAIL cw_strobe got %h required ab000104", d);
      end
      axi_write(32'h0, 32'h0, 4'hF);
   endtask

   task automatic test_rw_collision();
      logic [31:0] d;
      int lat;
      awaddr = 32'h8; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h8;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h10 || rresp !== 2'b00) begin
         errors++;
         $display("FAIL collide_old rvalid %b rdata %h required 1 00000010",
                  rvalid, rdata);
      end
      rready = 1'b1; bready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0; bready = 1'b0;
      axi_read(32'h8, d, lat);
      checks++;
      if (d !== 32'h55) begin
         errors++;
         $display("FAIL collide_new got %h required 00000055", d);
      end
   endtask

   task automatic test_ctrl();
      logic [31:0] d;
      int lat;
      axi_write(32'h0, 32'h0000FF00, 4'hF);
      axi_read(32'h0, d, lat);
`ifdef AXI_TIMER_PRESCALER_EN
      checks++;
      if (d !== 32'h0000FF00) begin
         errors++;
         $display("FAIL ctrl_presc got %h required 0000ff00", d);
      end
      axi_write(32'h8, 32'hFFFFFFFF, 4'hF);
      axi_write(32'h4, 32'h0, 4'hF);
      axi_write(32'h0, 32'h0301, 4'hF);
      repeat (39) @(posedge clk);
      #1;
      axi_read(32'h4, d, lat);
      checks++;
      if (d !== 32'd10) begin
         errors++;
         $display("FAIL presc_count got %h required 0000000a", d);
      end
      axi_write(32'h0, 32'h0, 4'hF);
`else
      checks++;
      if (d !== 32'h0) begin
         errors++;
         $display("FAIL ctrl_upper got %h required 0", d);
      end
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_reset_mid();
      test_slow_write();
      test_back_to_back();
      test_autoreload_irq();
      test_overflow();
      test_count_write();
      test_slow_write();
      test_rw_collision();
      test_ctrl();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
